// File: rtl/reg_share_arbiter.sv
// ============================================================================
// Module   : reg_share_arbiter
// Purpose  : Round-robin arbiter sharing one W-bit register among N async
//            4-phase req/ack requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_share_arbiter #(
   parameter int N           = 4,
   parameter int W           = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   localparam int ID_W       = $clog2(N)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N-1:0]      req,
   input  logic [N*W-1:0]    wdata,
   output logic [N-1:0]      ack,
   output logic [W-1:0]      q,
   output logic [ID_W-1:0]   grant_id,
   output logic              busy,
   output logic [CNT_W-1:0]  wr_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic [SYNC_STAGES-1:0][N-1:0]   sync_q, sync_d;
   logic [N-1:0]                    sreq;
   logic [N-1:0]                    ack_q, ack_d;
   logic [W-1:0]                    q_q, q_d;
   logic [ID_W-1:0]                 grant_q, grant_d;
   logic [ID_W-1:0]                 last_q, last_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic                            busy_q, busy_d;

   logic                            pick_valid;
   logic [ID_W-1:0]                 pick_id;
   logic [ID_W-1:0]                 cand;

   // Stage 0 samples the raw async request; the last stage feeds the FSM.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], req};
   end

   assign sreq = sync_q[SYNC_STAGES-1];

   // Walk from last+N down to last+1 so the nearest candidate after last wins.
   always_comb begin
      pick_valid = 1'b0;
      pick_id    = '0;
      cand       = '0;
      for (int k = N; k >= 1; k--) begin
         cand = ID_W'((int'(last_q) + k) % N);
         if (sreq[cand] && !ack_q[cand]) begin
            pick_valid = 1'b1;
            pick_id    = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      q_d     = q_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = pick_id;
               state_d = LOAD;
            end
         end
         LOAD: begin
            q_d            = wdata[int'(grant_q)*W +: W];
            ack_d[grant_q] = 1'b1;
            cnt_d          = cnt_q + 1'b1;
            state_d        = HOLD;
         end
         HOLD: begin
            if (!sreq[grant_q]) begin
               ack_d[grant_q] = 1'b0;
               last_d         = grant_q;
               state_d        = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            ack_d   = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sync_q  <= '0;
         ack_q   <= '0;
         q_q     <= '0;
         grant_q <= '0;
         last_q  <= ID_W'(N-1);
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         ack_q   <= ack_d;
         q_q     <= q_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   assign ack      = ack_q;
   assign q        = q_q;
   assign grant_id = grant_q;
   assign busy     = busy_q;
   assign wr_count = cnt_q;

endmodule

`default_nettype wire
